// File: rtl/demux_pkg.sv
// demux_pkg: definitions shared by demux14_stream and its channel slots.
//   chan_state_e : per-channel holding-register state (EMPTY / FULL)
//   DEF_W        : default data width in bits
//   DEF_CNT_W    : default per-channel transfer counter width
//   NUM_CH       : number of output channels
//   SEL_W        : width of the channel select
package demux_pkg;

   localparam int unsigned DEF_W     = 8;
   localparam int unsigned DEF_CNT_W = 8;
   localparam int unsigned NUM_CH    = 4;
   localparam int unsigned SEL_W     = 2;

   typedef enum logic [0:0] {
      EMPTY = 1'b0,
      FULL  = 1'b1
   } chan_state_e;

endpackage

// File: rtl/demux_slot.sv
// demux_slot: one output channel of the stream demultiplexer.
// Holds a single word. It fills when the top level steers an input transfer here,
// and it drains when the downstream accepts it. A word can drain and refill on the
// same edge, so a continuously ready consumer sees no bubble. It also counts completed
// output transfers, saturating at the all-ones value.
//
// Ports
//   clk      in   clock, rising edge
//   rst      in   synchronous active-high reset; dominates every other input
//   clr      in   synchronous clear of the transfer counter
//   wr_en    in   input transfer into this slot this cycle
//   wr_data  in   W  word written when wr_en=1
//   data     out  W  held word; it keeps the last written word after draining
//   valid    out  slot is FULL
//   ready    in   downstream consumes the held word
//   cnt      out  CNT_W  completed output transfers
module demux_slot
   import demux_pkg::*;
#(
   parameter int unsigned W     = DEF_W,
   parameter int unsigned CNT_W = DEF_CNT_W
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             clr,
   input  logic             wr_en,
   input  logic [W-1:0]     wr_data,
   output logic [W-1:0]     data,
   output logic             valid,
   input  logic             ready,
   output logic [CNT_W-1:0] cnt
);

   chan_state_e      state_q, state_d;
   logic [W-1:0]     data_q, data_d;
   logic [CNT_W-1:0] cnt_q, cnt_d;
   logic             out_xfer;

   localparam logic [CNT_W-1:0] CntMax = {CNT_W{1'b1}};

   assign out_xfer = (state_q == FULL) & ready;

   // Channel FSM and holding register
   always_comb begin
      state_d = state_q;
      data_d  = data_q;
      unique case (state_q)
         EMPTY: begin
            if (wr_en) begin
               state_d = FULL;
            end
         end
         FULL: begin
            // A refill on the drain edge keeps the slot FULL.
            if (wr_en) begin
               state_d = FULL;
            end else if (out_xfer) begin
               state_d = EMPTY;
            end
         end
         default: state_d = EMPTY;
      endcase
      if (wr_en) begin
         data_d = wr_data;
      end
   end

   // Saturating transfer counter. clr wins over a coincident increment.
   always_comb begin
      cnt_d = cnt_q;
      if (clr) begin
         cnt_d = '0;
      end else if (out_xfer && (cnt_q != CntMax)) begin
         cnt_d = cnt_q + 1'b1;
      end
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         state_q <= EMPTY;
         data_q  <= '0;
         cnt_q   <= '0;
      end else begin
         state_q <= state_d;
         data_q  <= data_d;
         cnt_q   <= cnt_d;
      end
   end

   assign data  = data_q;
   assign valid = (state_q == FULL);
   assign cnt   = cnt_q;

endmodule

// File: rtl/demux14_stream.sv
// demux14_stream: 1-to-4 valid/ready stream demultiplexer with per-channel
// one-entry holding registers and saturating output transfer counters.
// {s1,s0} selects the destination: 00->o0, 01->o1, 10->o2, 11->o3.
// The top level only decodes the select and forms in_ready. The holding registers,
// channel FSMs and counters are in demux_slot.
//
// Ports
//   clk, rst                 clock; synchronous active-high reset
//   in_data/in_valid         offered word and its valid
//   in_ready                 the selected channel can take the word this cycle
//   s1, s0                   destination select
//   clr                      synchronous clear of all transfer counters
//   oK_data/oK_valid/oK_ready  channel K output stream (K = 0..3)
//   c0..c3                   completed output transfers per channel
module demux14_stream
   import demux_pkg::*;
#(
   parameter int unsigned W     = DEF_W,
   parameter int unsigned CNT_W = DEF_CNT_W
) (
   input  logic             clk,
   input  logic             rst,
   input  logic [W-1:0]     in_data,
   input  logic             in_valid,
   output logic             in_ready,
   input  logic             s1,
   input  logic             s0,
   input  logic             clr,
   output logic [W-1:0]     o0_data,
   output logic [W-1:0]     o1_data,
   output logic [W-1:0]     o2_data,
   output logic [W-1:0]     o3_data,
   output logic             o0_valid,
   output logic             o1_valid,
   output logic             o2_valid,
   output logic             o3_valid,
   input  logic             o0_ready,
   input  logic             o1_ready,
   input  logic             o2_ready,
   input  logic             o3_ready,
   output logic [CNT_W-1:0] c0,
   output logic [CNT_W-1:0] c1,
   output logic [CNT_W-1:0] c2,
   output logic [CNT_W-1:0] c3
);

   logic [SEL_W-1:0]  sel;
   logic [NUM_CH-1:0] hit;
   logic [NUM_CH-1:0] wr_en;
   logic [NUM_CH-1:0] slot_valid;
   logic [NUM_CH-1:0] slot_ready;
   logic [W-1:0]      slot_data [NUM_CH];
   logic [CNT_W-1:0]  slot_cnt  [NUM_CH];
   logic              in_xfer;

   assign sel        = {s1, s0};
   assign slot_ready = {o3_ready, o2_ready, o1_ready, o0_ready};

   // One-hot select decode
   always_comb begin
      hit      = '0;
      hit[sel] = 1'b1;
   end

   // Combinational on the selected channel's downstream ready, so a FULL slot
   // being drained can still accept a word on the same edge.
   assign in_ready = ~slot_valid[sel] | slot_ready[sel];
   assign in_xfer  = in_valid & in_ready;
   assign wr_en    = hit & {NUM_CH{in_xfer}};

   for (genvar k = 0; k < NUM_CH; k++) begin : g_slot
      demux_slot #(
         .W     (W),
         .CNT_W (CNT_W)
      ) u_slot (
         .clk     (clk),
         .rst     (rst),
         .clr     (clr),
         .wr_en   (wr_en[k]),
         .wr_data (in_data),
         .data    (slot_data[k]),
         .valid   (slot_valid[k]),
         .ready   (slot_ready[k]),
         .cnt     (slot_cnt[k])
      );
   end

   assign o0_data  = slot_data[0];
   assign o1_data  = slot_data[1];
   assign o2_data  = slot_data[2];
   assign o3_data  = slot_data[3];
   assign o0_valid = slot_valid[0];
   assign o1_valid = slot_valid[1];
   assign o2_valid = slot_valid[2];
   assign o3_valid = slot_valid[3];
   assign c0       = slot_cnt[0];
   assign c1       = slot_cnt[1];
   assign c2       = slot_cnt[2];
   assign c3       = slot_cnt[3];

endmodule

// File: tb/tb_demux14_stream.sv
// Directed and random-stream bench for demux14_stream (W=8, CNT_W=8).
module tb_demux14_stream;

   logic       clk = 1'b0;
   logic       rst = 1'b0;
   logic [7:0] in_data = '0;
   logic       in_valid = 1'b0;
   logic       in_ready;
   logic       s1 = 1'b0, s0 = 1'b0;
   logic       clr = 1'b0;
   logic [7:0] od [4];
   logic       ov [4];
   logic       rdy [4];
   logic [7:0] cc [4];

   int checks = 0;
   int errors = 0;

   always #5 clk = ~clk;

   demux14_stream dut (
      .clk      (clk),
      .rst      (rst),
      .in_data  (in_data),
      .in_valid (in_valid),
      .in_ready (in_ready),
      .s1       (s1),
      .s0       (s0),
      .clr      (clr),
      .o0_data  (od[0]),
      .o1_data  (od[1]),
      .o2_data  (od[2]),
      .o3_data  (od[3]),
      .o0_valid (ov[0]),
      .o1_valid (ov[1]),
      .o2_valid (ov[2]),
      .o3_valid (ov[3]),
      .o0_ready (rdy[0]),
      .o1_ready (rdy[1]),
      .o2_ready (rdy[2]),
      .o3_ready (rdy[3]),
      .c0       (cc[0]),
      .c1       (cc[1]),
      .c2       (cc[2]),
      .c3       (cc[3])
   );

   task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      checks++;
      assert (obs === exp)
      else begin
         errors++;
         $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
      end
   endtask

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic set_sel(input logic [1:0] s);
      s1 = s[1];
      s0 = s[0];
   endtask

   logic [7:0] q [4][$];
   logic [7:0] w;
   logic [1:0] sel;
   logic       acc;
   logic       exp_rdy;

   initial begin
      for (int k = 0; k < 4; k++) rdy[k] = 1'b0;

      // Reset
      rst = 1'b1;
      tick();
      rst = 1'b0;
      for (int k = 0; k < 4; k++) begin
         check($sformatf("rst_valid%0d", k), 32'(ov[k]), 0);
         check($sformatf("rst_data%0d", k), 32'(od[k]), 0);
         check($sformatf("rst_cnt%0d", k), 32'(cc[k]), 0);
         set_sel(2'(k));
         #1;
         check($sformatf("rst_in_ready_sel%0d", k), 32'(in_ready), 1);
      end

      // Single word to o2, downstream stalled
      set_sel(2'b10);
      in_data  = 8'hA5;
      in_valid = 1'b1;
      #1;
      check("o2_load_in_ready", 32'(in_ready), 1);
      tick();
      in_valid = 1'b0;
      check("o2_valid", 32'(ov[2]), 1);
      check("o2_data", 32'(od[2]), 32'hA5);
      check("o0_valid_idle", 32'(ov[0]), 0);
      check("o1_valid_idle", 32'(ov[1]), 0);
      check("o3_valid_idle", 32'(ov[3]), 0);

      // o1 full and stalled blocks its select; other selects are unaffected
      set_sel(2'b01);
      in_data  = 8'h5A;
      in_valid = 1'b1;
      tick();
      in_data = 8'h77;
      #1;
      check("o1_full_in_ready", 32'(in_ready), 0);
      tick();
      check("o1_hold_data", 32'(od[1]), 32'h5A);
      check("o1_hold_valid", 32'(ov[1]), 1);
      set_sel(2'b11);
      in_data = 8'h99;
      #1;
      check("o3_sel_in_ready", 32'(in_ready), 1);
      tick();
      in_valid = 1'b0;
      check("o3_valid", 32'(ov[3]), 1);
      check("o3_data", 32'(od[3]), 32'h99);
      check("o1_untouched", 32'(od[1]), 32'h5A);

      // o0 simultaneous drain and refill
      set_sel(2'b00);
      in_data  = 8'h11;
      in_valid = 1'b1;
      tick();
      rdy[0]  = 1'b1;
      in_data = 8'h3C;
      #1;
      check("o0_refill_in_ready", 32'(in_ready), 1);
      tick();
      in_valid = 1'b0;
      rdy[0]   = 1'b0;
      check("o0_refill_valid", 32'(ov[0]), 1);
      check("o0_refill_data", 32'(od[0]), 32'h3C);
      check("c0_after_refill", 32'(cc[0]), 1);

      // o2 drains; data is retained while EMPTY
      rdy[2] = 1'b1;
      tick();
      rdy[2] = 1'b0;
      check("o2_drained_valid", 32'(ov[2]), 0);
      check("o2_drained_data", 32'(od[2]), 32'hA5);
      check("c2_after_drain", 32'(cc[2]), 1);

      // Back-to-back o3 stream; counter saturates at 255
      set_sel(2'b11);
      in_valid = 1'b1;
      rdy[3]   = 1'b1;
      for (int i = 0; i < 200; i++) begin
         in_data = 8'(i);
         tick();
      end
      check("c3_after_200", 32'(cc[3]), 200);
      for (int i = 200; i < 300; i++) begin
         in_data = 8'(i);
         tick();
      end
      check("c3_saturated", 32'(cc[3]), 255);
      check("o3_stream_data", 32'(od[3]), 32'(8'(299)));
      check("o3_stream_valid", 32'(ov[3]), 1);

      // clr zeroes counters and beats a coincident increment on o0
      in_valid = 1'b0;
      rdy[3]   = 1'b0;
      rdy[0]   = 1'b1;
      clr      = 1'b1;
      tick();
      clr    = 1'b0;
      rdy[0] = 1'b0;
      check("c3_cleared", 32'(cc[3]), 0);
      check("c0_clr_dominates", 32'(cc[0]), 0);
      check("o0_drained_on_clr", 32'(ov[0]), 0);

      // Fill all four channels, with one extra completed transfer on o1
      rdy[1] = 1'b1;
      tick();
      rdy[1] = 1'b0;
      check("c1_one_xfer", 32'(cc[1]), 1);
      in_valid = 1'b1;
      for (int k = 0; k < 3; k++) begin
         set_sel(2'(k));
         in_data = 8'hC0 + 8'(k);
         tick();
      end
      in_valid = 1'b0;
      for (int k = 0; k < 4; k++) check($sformatf("all_full%0d", k), 32'(ov[k]), 1);

      // Reset mid-operation dominates everything
      rst      = 1'b1;
      clr      = 1'b0;
      in_valid = 1'b1;
      set_sel(2'b00);
      in_data  = 8'hEE;
      for (int k = 0; k < 4; k++) rdy[k] = 1'b1;
      tick();
      rst      = 1'b0;
      in_valid = 1'b0;
      for (int k = 0; k < 4; k++) rdy[k] = 1'b0;
      for (int k = 0; k < 4; k++) begin
         check($sformatf("rst2_valid%0d", k), 32'(ov[k]), 0);
         check($sformatf("rst2_data%0d", k), 32'(od[k]), 0);
         check($sformatf("rst2_cnt%0d", k), 32'(cc[k]), 0);
      end
      check("rst2_in_ready", 32'(in_ready), 1);

      // Random streams against a per-channel queue model
      acc = 1'b1;
      for (int cyc = 0; cyc < 10000; cyc++) begin
         // Hold a stalled offer stable
         if (acc || !in_valid) begin
            in_valid = 1'($urandom_range(0, 1));
            sel      = 2'($urandom_range(0, 3));
            w        = 8'($urandom);
            set_sel(sel);
            in_data = w;
         end
         for (int k = 0; k < 4; k++) rdy[k] = 1'($urandom_range(0, 1));
         #1;
         exp_rdy = (q[sel].size() == 0) || rdy[sel];
         check("rand_in_ready", 32'(in_ready), 32'(exp_rdy));
         for (int k = 0; k < 4; k++) begin
            check($sformatf("rand_valid%0d", k), 32'(ov[k]), 32'(q[k].size() != 0));
            if (q[k].size() != 0 && rdy[k]) begin
               check($sformatf("rand_data%0d", k), 32'(od[k]), 32'(q[k].pop_front()));
            end
         end
         acc = in_valid && exp_rdy;
         if (acc) q[sel].push_back(w);
         tick();
      end
      in_valid = 1'b0;
      for (int k = 0; k < 4; k++) rdy[k] = 1'b1;
      #1;
      for (int k = 0; k < 4; k++) begin
         if (q[k].size() != 0) begin
            check($sformatf("final_data%0d", k), 32'(od[k]), 32'(q[k].pop_front()));
         end
      end
      tick();
      for (int k = 0; k < 4; k++) check($sformatf("final_empty%0d", k), 32'(ov[k]), 0);

      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule

// File: doc/demux14_stream.md
DEMUX14_STREAM -- requirements
Module: demux14_stream

Interface
REQ-001 The block SHALL have parameter W, default 8, giving the data width in bits.
REQ-002 The block SHALL have parameter CNT_W, default 8, giving the per-channel transfer counter width.
REQ-003 clk  input  1  single clock; all state updates on rising edge.
REQ-004 rst  input  1  reset, synchronous, active-high.
REQ-005 in_data  input  W  word offered for dispatch.
REQ-006 in_valid  input  1  in_data and select are valid.
REQ-007 in_ready  output  1  block accepts the offered word this cycle.
REQ-008 s1, s0  input  1 each  destination select; {s1,s0} = 00->o0, 01->o1, 10->o2, 11->o3.
REQ-009 clr  input  1  synchronous clear of all transfer counters.
REQ-010 o0_data..o3_data  output  W each  held word per channel.
REQ-011 o0_valid..o3_valid  output  1 each  channel holds a word.
REQ-012 o0_ready..o3_ready  input  1 each  downstream consumes the channel word.
REQ-013 c0..c3  output  CNT_W each  completed output transfers per channel.

Function
REQ-014 Each channel k SHALL own a one-entry holding register with FSM states EMPTY (ok_valid=0) and FULL (ok_valid=1).
REQ-015 in_ready SHALL equal: selected channel EMPTY, or selected channel FULL with its ok_ready=1 (combinational).
REQ-016 An input transfer SHALL occur at an edge where in_valid=1 and in_ready=1; in_data SHALL be written to the channel named by {s1,s0} sampled at that edge.
REQ-017 Latency SHALL be one cycle: a word accepted at edge N SHALL appear on ok_data with ok_valid=1 from edge N onward.
REQ-018 Output transfer on channel k SHALL occur at an edge where ok_valid=1 and ok_ready=1.
REQ-019 Transitions: EMPTY->FULL on input transfer; FULL->EMPTY on output transfer without input transfer; FULL->FULL with new data on simultaneous output and input transfer (no bubble).
REQ-020 A FULL channel with ok_ready=0 SHALL hold ok_data unchanged.
REQ-021 Channels not selected SHALL be unaffected by input activity; output transfers on several channels in the same cycle SHALL all complete.
REQ-022 ok_data SHALL be unspecified-free: it SHALL retain the last written word when EMPTY.
REQ-023 ck SHALL increment by 1 on each output transfer of channel k, saturating at 2^CNT_W-1.
REQ-024 clr=1 SHALL zero all counters at that edge; clr SHALL dominate a coincident increment.
REQ-025 Upstream SHALL keep in_data and {s1,s0} stable while in_valid=1 and in_ready=0; the block SHALL NOT depend on this for correctness of already-held words.
REQ-026 in_valid=0 SHALL never modify any holding register.

Reset
REQ-027 While rst=1 at an edge: all channels EMPTY, all ok_valid=0, all ok_data=0, all ck=0.
REQ-028 rst SHALL dominate clr, input transfers and output transfers; held words SHALL be discarded on reset mid-operation.
REQ-029 After reset, in_ready SHALL be 1 for any select.

Structure
REQ-030 Shared package demux_pkg SHALL hold the channel-state typedef (EMPTY, FULL), default W, and default CNT_W.
REQ-031 One sub-module demux_slot (holding register, channel FSM, saturating counter) SHALL be instantiated four times; top level holds only select decode and in_ready mux.

Verification
REQ-032 Reset then {s1,s0}=10, in_data=8'hA5, in_valid=1 one cycle, o2_ready=0 -> o2_valid=1, o2_data=A5 next cycle; o0/o1/o3_valid=0.
REQ-033 o1 FULL, o1_ready=0, select 01 with in_valid=1 -> in_ready=0, o1_data unchanged; select 11 same cycle -> in_ready=1, word lands in o3.
REQ-034 o0 FULL, o0_ready=1, select 00 with new word 8'h3C -> simultaneous drain/refill, o0_valid stays 1, o0_data=3C, c0 increments by 1.
REQ-035 300 back-to-back transfers to o3 with o3_ready=1 -> c3 saturates at 255; clr=1 -> c3=0 next cycle.
REQ-036 All four channels FULL, rst=1 one cycle -> all valids 0, all data 0, all counters 0, in_ready=1.
REQ-037 Random select/valid/ready streams, 10k cycles -> per-channel output word order equals input order per channel, no loss or duplication.
